// File: rtl/mpy_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mpy_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of a counter able to index 0..n-1; evaluated at elaboration.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mpy_step.sv
// One shift-add iteration: adds (or, for the signed MSB, subtracts) the shifted
// multiplicand when the selected multiplier bit is set.
module mpy_step
   import mpy_pkg::*;
#(
   parameter  int WIDTH = 4,
   localparam int CNT_W = clog2(WIDTH),
   localparam int PW    = 2 * WIDTH
) (
   input  logic [PW-1:0]    acc,
   input  logic [PW-1:0]    mcand,
   input  logic             bit_in,
   input  logic [CNT_W-1:0] idx,
   input  logic             is_signed,
   output logic [PW-1:0]    acc_next
);

   logic [PW-1:0] addend;
   logic          msb_sub;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      addend   = mcand << idx;
      msb_sub  = is_signed && (idx == CNT_W'(WIDTH - 1));
      acc_next = acc;
      if (bit_in) begin
         // The two's-complement MSB carries weight -2^(WIDTH-1).
         acc_next = msb_sub ? (acc - addend) : (acc + addend);
      end
   end

endmodule

// File: rtl/seq_mpy.sv
// Sequential WIDTH x WIDTH multiplier, one multiplier bit per clock, with a
// start/busy/done handshake and a per-operation signed/unsigned mode.
module seq_mpy
   import mpy_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CNT_W = clog2(WIDTH);
   localparam int PW    = 2 * WIDTH;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [PW-1:0]    mcand;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    acc_next;
   logic [WIDTH-1:0] mplier;
   logic             sgn;
   logic             accept;
   logic             last;

   assign accept = start && ((state == IDLE) || (state == DONE));
   assign last   = (cnt == CNT_W'(WIDTH - 1));

   // State register; reset is asynchronous so busy/done drop without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (last)  state_nxt = DONE;
         DONE:    state_nxt = start ? CALC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == CALC);
      done = (state == DONE);
   end

   mpy_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .acc      (acc),
      .mcand    (mcand),
      .bit_in   (mplier[cnt]),
      .idx      (cnt),
      .is_signed(sgn),
      .acc_next (acc_next)
   );

   // Operands are captured only on an accepted start, so mid-operation input
   // changes never reach the datapath; product moves only on CALC->DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         mplier  <= '0;
         sgn     <= 1'b0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (accept) begin
         mcand   <= is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
         mplier  <= b;
         sgn     <= is_signed;
         acc     <= '0;
         cnt     <= '0;
      end else if (state == CALC) begin
         acc <= acc_next;
         cnt <= cnt + CNT_W'(1);
         if (last) product <= acc_next;
      end
   end

endmodule

// File: tb/tb_seq_mpy.sv
// Directed and random checks of seq_mpy at WIDTH=4 and WIDTH=8.
module tb_seq_mpy;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        start4, sgn4, busy4, done4;
   logic [3:0]  a4, b4;
   logic [7:0]  product4;

   logic        start8, sgn8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] product8;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_mpy #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .is_signed(sgn4),
      .a(a4), .b(b4), .busy(busy4), .done(done4), .product(product4)
   );

   seq_mpy #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sgn8),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref8(input logic s, input logic [7:0] x, input logic [7:0] y);
      logic signed [15:0] xs, ys;
      if (s) begin
         xs = {{8{x[7]}}, x};
         ys = {{8{y[7]}}, y};
         return 16'(xs * ys);
      end
      return {8'h00, x} * {8'h00, y};
   endfunction

   task automatic op4(input string tag, input logic s, input logic [3:0] x, input logic [3:0] y,
                      input logic [7:0] exp);
      int n, nb;
      sgn4 = s; a4 = x; b4 = y; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      n = 0; nb = 0;
      while (!done4 && n < 20) begin
         if (busy4) nb++;
         @(posedge clk); #1;
         n++;
      end
      check({tag, " latency"}, 64'(n), 64'd4);
      check({tag, " busy_cycles"}, 64'(nb), 64'd4);
      check({tag, " product"}, 64'(product4), 64'(exp));
      check({tag, " busy_in_done"}, 64'(busy4), 64'd0);
      @(posedge clk); #1;
      check({tag, " done_one_cycle"}, 64'(done4), 64'd0);
   endtask

   task automatic op8(input string tag, input logic s, input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] exp);
      int n;
      sgn8 = s; a8 = x; b8 = y; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      n = 0;
      while (!done8 && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, " latency"}, 64'(n), 64'd8);
      check({tag, " product"}, 64'(product8), 64'(exp));
      @(posedge clk); #1;
      check({tag, " done_one_cycle"}, 64'(done8), 64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] pa [3];
      logic [3:0] pb [3];
      logic [7:0] pe [3];
      int         ndone;
      int         n;
      logic [7:0] ra, rb;

      rst_n = 1'b0;
      start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
      start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
      #12;
      check("reset busy4", 64'(busy4), 64'd0);
      check("reset done4", 64'(done4), 64'd0);
      check("reset product4", 64'(product4), 64'd0);
      check("reset product8", 64'(product8), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      op4("s_m3x5", 1'b1, 4'hD, 4'h5, 8'hF1);
      op4("s_m8xm8", 1'b1, 4'h8, 4'h8, 8'h40);
      op4("u_15x15", 1'b0, 4'hF, 4'hF, 8'hE1);

      // Inputs disturbed mid-operation must not affect the result.
      sgn4 = 1'b1; a4 = 4'h7; b4 = 4'h7; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(posedge clk); #1;
      start4 = 1'b1; a4 = 4'h1; b4 = 4'h1; sgn4 = 1'b0;
      @(posedge clk); #1;
      start4 = 1'b0;
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done4) begin
            ndone++;
            check("busy_ignore product", 64'(product4), 64'h31);
         end
      end
      check("busy_ignore done_count", 64'(ndone), 64'd1);

      // Back-to-back with start held high.
      pa[0] = 4'h2; pb[0] = 4'h3; pe[0] = 8'h06;
      pa[1] = 4'hF; pb[1] = 4'hF; pe[1] = 8'h01;
      pa[2] = 4'h7; pb[2] = 4'h8; pe[2] = 8'hC8;
      sgn4 = 1'b1; a4 = pa[0]; b4 = pb[0]; start4 = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (!done4 && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         check($sformatf("b2b%0d latency", k), 64'(n), 64'd4);
         check($sformatf("b2b%0d product", k), 64'(product4), 64'(pe[k]));
         if (k < 2) begin
            a4 = pa[k+1]; b4 = pb[k+1];
         end else begin
            start4 = 1'b0;
         end
         @(posedge clk); #1;
         check($sformatf("b2b%0d next_busy", k), 64'(busy4), (k < 2) ? 64'd1 : 64'd0);
      end

      // Asynchronous reset two cycles into CALC.
      sgn4 = 1'b1; a4 = 4'h5; b4 = 4'h3; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_reset busy4", 64'(busy4), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst busy4", 64'(busy4), 64'd0);
      check("async_rst done4", 64'(done4), 64'd0);
      check("async_rst product4", 64'(product4), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      op4("s_3xm2", 1'b1, 4'h3, 4'hE, 8'hFA);

      op8("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000);
      op8("u_255x255", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
      op8("s_m1x127", 1'b1, 8'hFF, 8'h7F, 16'hFF81);

      for (int i = 0; i < 1000; i++) begin
         for (int s = 0; s < 2; s++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            op8($sformatf("rnd%0d_%s", i, s ? "s" : "u"), s[0], ra, rb, ref8(s[0], ra, rb));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_mpy.md
# seq_mpy

Parametrised sequential shift-add multiplier. It is the next generation of the team's 4-bit clocked multiplier, generalised to WIDTH-bit operands, with a per-operation signed/unsigned mode and a start/busy/done handshake in place of free-running recomputation. It sits on the datapath as a shared arithmetic unit that takes one multiplier bit per clock, and it is driven by a controller or a self-checking bench.

## Interface
- WIDTH, default 4: operand width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; sampled only when the unit can accept (IDLE or DONE).
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when product becomes valid.
- product  out  2*WIDTH  result register; holds the last result until the next completion.

## Operation
- States:
  - IDLE: reset state.
  - CALC: one iteration per clock.
  - DONE: one cycle, done=1.
- Transitions:
  - IDLE --start--> CALC.
  - CALC --(cnt==WIDTH-1)--> DONE.
  - DONE --start--> CALC.
  - DONE --!start--> IDLE.
- Operand latch: on an accepted start, register a, b and is_signed; clear the accumulator (2*WIDTH bits); set cnt=0.
- Iteration i (i = 0..WIDTH-1):
  - If b[i]=1, add the extended multiplicand shifted left by i to the accumulator.
  - The extended multiplicand is a sign-extended to 2*WIDTH bits if is_signed, else zero-extended.
  - If is_signed and i=WIDTH-1, subtract instead of add (weight of the MSB is negative).
  - All arithmetic is modulo 2^(2*WIDTH). The result is exact for both modes: no overflow is possible in 2*WIDTH bits.
- Output update: product is written only on the CALC->DONE edge. Intermediate accumulator values are never visible on product.
- Busy behaviour: start, a, b and is_signed are ignored while in CALC. Changing inputs mid-operation has no effect on the result.
- Reset mid-operation: the state returns to IDLE immediately and all outputs go to 0. The in-flight result is discarded.

## Timing
- Reset values: busy=0, done=0, product=0, state IDLE, cnt=0, accumulator 0.
- Latency:
  - Start sampled at edge E0.
  - busy=1 from after E0 through after E(WIDTH-1).
  - Product is updated and done=1 after edge E(WIDTH). The result is visible WIDTH+1 edges after start.
- done is high for exactly one cycle per completed operation; busy=0 during that cycle.
- Back-to-back: start=1 during the DONE cycle is accepted at the next edge. Throughput is one result per WIDTH+1 cycles, with no idle bubble.
- Start held high continuously produces continuous back-to-back operations, with a new operand sample at each DONE edge.
- product is stable from the done pulse until the next done pulse. It is not cleared on start.

## Structure
- Package mpy_pkg holds:
  - the state enumeration (IDLE, CALC, DONE);
  - the counter-width function clog2(WIDTH) for cnt.
- Sub-module mpy_step: combinational single iteration.
  - Inputs: accumulator, extended multiplicand, multiplier bit, index, is_signed.
  - Output: next accumulator, including the subtract-on-MSB rule.
- seq_mpy holds only the FSM, the counter, the operand and result registers, and the handshake.

## Test plan
- WIDTH=4, signed, a=-3 (4'hD), b=5: start at E0 -> done pulse after E4; product=8'hF1 (-15); busy high for exactly 4 cycles.
- WIDTH=4, signed, a=-8, b=-8 -> product=8'h40 (64). Then unsigned, a=15, b=15 -> product=8'hE1 (225). The same bit patterns are interpreted differently per is_signed.
- WIDTH=4, start a=7, b=7 signed. During CALC, pulse start with a=1, b=1 and toggle is_signed -> product=49; exactly one done pulse.
- WIDTH=4, start held high with the operand pairs (2,3), (-1,-1), (7,-8) presented at each DONE edge -> done pulses every 5 cycles with product 6, 1, -56 in order; no bubble cycles.
- Reset mid-operation: assert rst_n=0 asynchronously two cycles into CALC -> busy, done and product go to 0 immediately with no clock edge required. After release and a new start with a=3, b=-2 signed -> product=-6 after the normal latency.
- WIDTH=8, signed, a=-128, b=-128 -> product=16'h4000. WIDTH=8, unsigned, a=255, b=255 -> product=16'hFE01. Also run 1000 random operands in both modes against a reference multiply; zero mismatches and exactly one done pulse per start.
